// File: rtl/mem_arbiter.sv
// Fixed-priority (data over fetch) arbiter sharing one memory bus between fetch and load/store ports.
// Latency: bus_req one cycle after the request; ack combinational with bus_ack or timeout; requesters stall until acked.
package mem_arbiter_pkg;
  typedef logic [31:0] u32_t;
  typedef logic [3:0]  wrstb_t;
  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'd0,
    MEM_OP_LOAD  = 2'd1,
    MEM_OP_STORE = 2'd2
  } mem_op_e;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    if_req,
  input  u32_t    if_addr,
  output logic    if_ack,
  output u32_t    if_rdata,
  input  logic    mem_req,
  input  mem_op_e mem_op,
  input  u32_t    mem_addr,
  input  u32_t    mem_wdata,
  input  wrstb_t  mem_wrstb,
  output logic    mem_ack,
  output u32_t    mem_rdata,
  output logic    err,
  output logic    bus_req,
  output logic    bus_we,
  output u32_t    bus_addr,
  output u32_t    bus_wdata,
  output wrstb_t  bus_wrstb,
  input  logic    bus_ack,
  input  u32_t    bus_rdata,
  output logic    if_stall,
  output logic    mem_stall
);

  localparam int unsigned CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

  typedef enum logic [1:0] {IDLE, IFETCH, DATA} state_e;

  state_e        state;
  logic [CW-1:0] wait_cnt;
  logic          mem_vld;
  logic          is_store;
  logic          timeout;
  logic          done;

  assign mem_vld  = mem_req && ((mem_op == MEM_OP_LOAD) || (mem_op == MEM_OP_STORE));
  assign is_store = (mem_op == MEM_OP_STORE);

  // A bus_ack on the limit cycle wins over the timeout.
  assign timeout = (WAIT_MAX != 0) && (state != IDLE) && (wait_cnt == WAIT_LIM) && !bus_ack;
  assign done    = (state != IDLE) && (bus_ack || timeout);

  assign if_ack    = (state == IFETCH) && done;
  assign mem_ack   = (state == DATA) && done;
  assign err       = timeout;
  assign if_rdata  = ((state == IFETCH) && bus_ack) ? bus_rdata : '0;
  assign mem_rdata = ((state == DATA) && bus_ack && !bus_we) ? bus_rdata : '0;
  assign if_stall  = if_req && !if_ack;
  assign mem_stall = mem_vld && !mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wrstb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_vld) begin
            state     <= DATA;
            wait_cnt  <= '0;
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_addr  <= mem_addr;
            bus_wdata <= is_store ? mem_wdata : '0;
            bus_wrstb <= is_store ? mem_wrstb : '0;
          end else if (if_req) begin
            state     <= IFETCH;
            wait_cnt  <= '0;
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
            bus_wrstb <= '0;
          end
        end
        default: begin
          if (done) begin
            state   <= IDLE;
            bus_req <= 1'b0;
          end else if ((WAIT_MAX != 0) && bus_req && !bus_ack) begin
            // Not done implies below the limit, so this never wraps.
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule
